// File: rtl/rd_req_arbiter_pkg.sv
// rtl/rd_req_arbiter_pkg.sv - shared FSM encoding and sizing helper for the read-request path
//
// Purpose : types and helpers shared by rd_req_arbiter and the read_info path.
// Contents: rd_state_e - arbiter FSM state encoding (IDLE / SPLIT)
//           clog2()    - ceiling log2, usable in constant expressions
package rd_req_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } rd_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_req_arbiter_rr.sv
// rtl/rd_req_arbiter_rr.sv - round-robin one-hot grant over the PU request vector
//
// Purpose : purely combinational round-robin pick. The first asserted request
//           found searching from last_grant+1 (wrapping modulo NUM_PU) wins.
// Ports   : req        in  NUM_PU  request vector
//           last_grant in  ID_W    index of the most recently served PU
//           grant      out NUM_PU  one-hot grant, all-zero when req is empty
//           grant_id   out ID_W    index of the granted PU (0 when none)
module rr_arbiter #(
  parameter int NUM_PU = 4,
  parameter int ID_W   = 3
) (
  input  logic [NUM_PU-1:0] req,
  input  logic [ID_W-1:0]   last_grant,
  output logic [NUM_PU-1:0] grant,
  output logic [ID_W-1:0]   grant_id
);

  // Each requester gets a distance from last_grant+1; the smallest wins.
  // last_grant never exceeds NUM_PU-1, so one wrap correction suffices.
  always_comb begin
    int d;
    int best_d;
    d        = 0;
    best_d   = NUM_PU;
    grant    = '0;
    grant_id = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      d = i - int'(last_grant) - 1;
      if (d < 0) d = d + NUM_PU;
      if (req[i] && (d < best_d)) begin
        best_d   = d;
        grant    = '0;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rd_req_arbiter.sv
// rtl/rd_req_arbiter.sv - arbitrates PU read requests and splits them into bounded chunks
//
// Purpose : accepts one PU request at a time (round-robin), then issues it as a
//           burst of rd_req strobes of at most MAX_CHUNK each, throttled by the
//           downstream read_info FIFO and by the in-flight read limit.
// Ports   : clk, reset_n       clock, async active-low reset
//           pu_req_valid/ready per-PU request handshake (ready one-hot, comb)
//           pu_req_size/d_type per-PU request fields, PU i at slice i
//           read_info_full     blocks issue while high
//           rd_req             single-cycle issue strobe
//           rd_req_size/pu_id/d_type  issued chunk fields, held when idle
//           rd_done            one pulse per completed read
//           busy, outstanding  activity flag and in-flight read count
module rd_req_arbiter
  import rd_req_arbiter_pkg::*;
#(
  parameter int  NUM_PU          = 4,
  parameter int  D_TYPE_W        = 2,
  parameter int  RD_SIZE_W       = 20,
  parameter int  MAX_CHUNK       = 256,
  parameter int  MAX_OUTSTANDING = 8,
  localparam int PU_ID_W         = clog2(NUM_PU) + 1,
  localparam int OUT_W           = clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PU-1:0]            pu_req_valid,
  output logic [NUM_PU-1:0]            pu_req_ready,
  input  logic [NUM_PU*RD_SIZE_W-1:0]  pu_req_size,
  input  logic [NUM_PU*D_TYPE_W-1:0]   pu_req_d_type,
  input  logic                         read_info_full,
  output logic                         rd_req,
  output logic [RD_SIZE_W-1:0]         rd_req_size,
  output logic [PU_ID_W-1:0]           rd_req_pu_id,
  output logic [D_TYPE_W-1:0]          rd_req_d_type,
  input  logic                         rd_done,
  output logic                         busy,
  output logic [OUT_W-1:0]             outstanding
);

  localparam logic [RD_SIZE_W-1:0] CHUNK_MAX = RD_SIZE_W'(MAX_CHUNK);
  localparam logic [OUT_W-1:0]     OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

  rd_state_e              state;
  rd_state_e              state_nxt;
  logic [PU_ID_W-1:0]     last_grant;
  logic [PU_ID_W-1:0]     cur_id;
  logic [D_TYPE_W-1:0]    cur_type;
  logic [RD_SIZE_W-1:0]   remaining;
  logic [RD_SIZE_W-1:0]   chunk;
  logic [RD_SIZE_W-1:0]   hold_size;
  logic [PU_ID_W-1:0]     hold_id;
  logic [D_TYPE_W-1:0]    hold_type;
  logic [NUM_PU-1:0]      grant;
  logic [PU_ID_W-1:0]     grant_id;
  logic [RD_SIZE_W-1:0]   sel_size;
  logic [D_TYPE_W-1:0]    sel_type;
  logic                   handshake;
  logic                   last_chunk;
  logic                   done_eff;

  rr_arbiter #(
    .NUM_PU (NUM_PU),
    .ID_W   (PU_ID_W)
  ) u_rr (
    .req        (pu_req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Fields of whichever PU the arbiter picked.
  always_comb begin
    sel_size = '0;
    sel_type = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (grant[i]) begin
        sel_size = pu_req_size[i*RD_SIZE_W +: RD_SIZE_W];
        sel_type = pu_req_d_type[i*D_TYPE_W +: D_TYPE_W];
      end
    end
  end

  assign chunk      = (remaining > CHUNK_MAX) ? CHUNK_MAX : remaining;
  assign last_chunk = (chunk == remaining);
  assign handshake  = |(pu_req_valid & pu_req_ready);
  // A completion with nothing in flight is spurious and dropped.
  assign done_eff   = rd_done && (outstanding != '0);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state; a zero-size request is consumed without leaving IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (handshake && (sel_size != '0)) state_nxt = ST_SPLIT;
      ST_SPLIT: if (rd_req && last_chunk)          state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs. Ready is masked by reset_n so it drops the instant reset
  // asserts, even though the arbiter inputs may still show valid requests.
  always_comb begin
    pu_req_ready = '0;
    rd_req       = 1'b0;
    case (state)
      ST_IDLE:  if (reset_n) pu_req_ready = grant;
      ST_SPLIT: rd_req = !read_info_full && (outstanding < OUT_MAX);
      default:  ;
    endcase
  end

  // Issued fields are live during a strobe and frozen at the last issue otherwise.
  assign rd_req_size   = rd_req ? chunk    : hold_size;
  assign rd_req_pu_id  = rd_req ? cur_id   : hold_id;
  assign rd_req_d_type = rd_req ? cur_type : hold_type;
  assign busy          = (state != ST_IDLE) || (outstanding != '0);

  // Request datapath. handshake (IDLE) and rd_req (SPLIT) never coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PU_ID_W'(NUM_PU - 1);
      cur_id     <= '0;
      cur_type   <= '0;
      remaining  <= '0;
      hold_size  <= '0;
      hold_id    <= '0;
      hold_type  <= '0;
    end else begin
      if (handshake) begin
        remaining <= sel_size;
        cur_type  <= sel_type;
        cur_id    <= grant_id;
        if (sel_size == '0) last_grant <= grant_id;
      end
      if (rd_req) begin
        remaining <= remaining - chunk;
        hold_size <= chunk;
        hold_id   <= cur_id;
        hold_type <= cur_type;
        if (last_chunk) last_grant <= cur_id;
      end
    end
  end

  // In-flight count; simultaneous issue and completion cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (rd_req && !done_eff) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!rd_req && done_eff) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_rd_req_arbiter.sv
// tb/tb_rd_req_arbiter.sv - directed and randomized self-checking bench for rd_req_arbiter
module tb_rd_req_arbiter;

  localparam int NUM_PU    = 4;
  localparam int D_TYPE_W  = 2;
  localparam int RD_SIZE_W = 20;
  localparam int MAX_CHUNK = 256;
  localparam int MAX_OUT   = 8;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic [NUM_PU-1:0]           pu_req_valid;
  logic [NUM_PU-1:0]           pu_req_ready;
  logic [NUM_PU*RD_SIZE_W-1:0] pu_req_size;
  logic [NUM_PU*D_TYPE_W-1:0]  pu_req_d_type;
  logic                        read_info_full;
  logic                        rd_req;
  logic [RD_SIZE_W-1:0]        rd_req_size;
  logic [2:0]                  rd_req_pu_id;
  logic [D_TYPE_W-1:0]         rd_req_d_type;
  logic                        rd_done;
  logic                        busy;
  logic [3:0]                  outstanding;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rd_req_arbiter #(
    .NUM_PU          (NUM_PU),
    .D_TYPE_W        (D_TYPE_W),
    .RD_SIZE_W       (RD_SIZE_W),
    .MAX_CHUNK       (MAX_CHUNK),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pu_req_valid   (pu_req_valid),
    .pu_req_ready   (pu_req_ready),
    .pu_req_size    (pu_req_size),
    .pu_req_d_type  (pu_req_d_type),
    .read_info_full (read_info_full),
    .rd_req         (rd_req),
    .rd_req_size    (rd_req_size),
    .rd_req_pu_id   (rd_req_pu_id),
    .rd_req_d_type  (rd_req_d_type),
    .rd_done        (rd_done),
    .busy           (busy),
    .outstanding    (outstanding)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pu_req_valid   = '0;
    pu_req_size    = '0;
    pu_req_d_type  = '0;
    read_info_full = 1'b0;
    rd_done        = 1'b0;
  endtask

  task automatic set_req(input int pu, input int size, input int dtype);
    pu_req_valid[pu] = 1'b1;
    pu_req_size[pu*RD_SIZE_W +: RD_SIZE_W]  = RD_SIZE_W'(size);
    pu_req_d_type[pu*D_TYPE_W +: D_TYPE_W]  = D_TYPE_W'(dtype);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    reset_n = 1'b1;
  endtask

  task automatic drain(input int n);
    rd_done = 1'b1;
    repeat (n) step();
    rd_done = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    pu_req_valid = 4'b0101;
    settle();
    n_cmp++;
    if ({pu_req_ready, rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, busy, outstanding} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs ready=%b rd_req=%b size=%0d id=%0d type=%0d busy=%b out=%0d required all 0",
               pu_req_ready, rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, busy, outstanding);
    end
    step();
    reset_n = 1'b1;
    pu_req_valid = '0;
    settle();
    n_cmp++;
    if ({busy, pu_req_ready, rd_req} !== '0) begin
      n_bad++;
      $display("FAIL reset_release busy=%b ready=%b rd_req=%b required 0", busy, pu_req_ready, rd_req);
    end
    step();
  endtask

  task automatic test_split_600();
    set_req(0, 600, 2);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0001) begin n_bad++; $display("FAIL split_grant got=%b required=0001", pu_req_ready); end
    step();
    pu_req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = (k < 2) ? 256 : 88;
      settle();
      n_cmp++;
      if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, outstanding} !==
          {1'b1, RD_SIZE_W'(sz), 3'd0, 2'd2, 4'(k)}) begin
        n_bad++;
        $display("FAIL split_chunk%0d got rd_req=%b size=%0d id=%0d type=%0d out=%0d required 1/%0d/0/2/%0d",
                 k, rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, outstanding, sz, k);
      end
      step();
    end
    settle();
    n_cmp++;
    if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, outstanding, busy} !==
        {1'b0, 20'd88, 3'd0, 2'd2, 4'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL split_done rd_req=%b size=%0d id=%0d type=%0d out=%0d busy=%b required 0/88/0/2/3/1",
               rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, outstanding, busy);
    end
    step();
    drain(3);
    settle();
    n_cmp++;
    if ({busy, outstanding} !== 5'd0) begin
      n_bad++; $display("FAIL split_drain busy=%b out=%0d required 0/0", busy, outstanding);
    end
    step();
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_req(1, 100, 1);
    set_req(3, 50, 3);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0010) begin n_bad++; $display("FAIL rr_first got=%b required=0010", pu_req_ready); end
    step();
    pu_req_valid[1] = 1'b0;
    settle();
    n_cmp++;
    if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, pu_req_ready} !== {1'b1, 20'd100, 3'd1, 2'd1, 4'b0000}) begin
      n_bad++; $display("FAIL rr_issue1 rd_req=%b size=%0d id=%0d ready=%b required 1/100/1/0000",
                        rd_req, rd_req_size, rd_req_pu_id, pu_req_ready);
    end
    step();
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b1000) begin n_bad++; $display("FAIL rr_second got=%b required=1000", pu_req_ready); end
    step();
    pu_req_valid[3] = 1'b0;
    set_req(1, 300, 0);
    settle();
    n_cmp++;
    if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type} !== {1'b1, 20'd50, 3'd3, 2'd3}) begin
      n_bad++; $display("FAIL rr_issue3 rd_req=%b size=%0d id=%0d type=%0d required 1/50/3/3",
                        rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type);
    end
    step();
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0010) begin n_bad++; $display("FAIL rr_third got=%b required=0010", pu_req_ready); end
    step();
    pu_req_valid = '0;
    step();
    settle();
    n_cmp++;
    if ({rd_req, rd_req_size, rd_req_pu_id} !== {1'b1, 20'd44, 3'd1}) begin
      n_bad++; $display("FAIL rr_tail rd_req=%b size=%0d id=%0d required 1/44/1", rd_req, rd_req_size, rd_req_pu_id);
    end
    step();
    drain(4);
  endtask

  task automatic test_full_stall();
    set_req(2, 1000, 1);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0100) begin n_bad++; $display("FAIL full_grant got=%b required=0100", pu_req_ready); end
    step();
    pu_req_valid = '0;
    step();
    read_info_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      n_cmp++;
      if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type} !== {1'b0, 20'd256, 3'd2, 2'd1}) begin
        n_bad++; $display("FAIL full_hold%0d rd_req=%b size=%0d id=%0d type=%0d required 0/256/2/1",
                          k, rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type);
      end
      step();
    end
    read_info_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = (k < 2) ? 256 : 232;
      settle();
      n_cmp++;
      if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type} !== {1'b1, RD_SIZE_W'(sz), 3'd2, 2'd1}) begin
        n_bad++; $display("FAIL full_resume%0d rd_req=%b size=%0d id=%0d required 1/%0d/2",
                          k, rd_req, rd_req_size, rd_req_pu_id, sz);
      end
      step();
    end
    drain(4);
  endtask

  task automatic test_outstanding_limit();
    int cnt;
    set_req(1, 4096, 3);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0010) begin n_bad++; $display("FAIL lim_grant got=%b required=0010", pu_req_ready); end
    step();
    pu_req_valid = '0;
    cnt = 0;
    repeat (12) begin settle(); if (rd_req) cnt++; step(); end
    n_cmp++;
    if (cnt != 8) begin n_bad++; $display("FAIL lim_count got=%0d required=8", cnt); end
    n_cmp++;
    if (outstanding !== 4'd8) begin n_bad++; $display("FAIL lim_out got=%0d required=8", outstanding); end
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    cnt = 0;
    repeat (6) begin settle(); if (rd_req) cnt++; step(); end
    n_cmp++;
    if (cnt != 1) begin n_bad++; $display("FAIL lim_one_more got=%0d required=1", cnt); end
    rd_done = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      settle();
      if (rd_req) cnt++;
      if (!busy) break;
      step();
    end
    n_cmp++;
    if ({busy, outstanding} !== 5'd0 || cnt != 7) begin
      n_bad++; $display("FAIL lim_finish busy=%b out=%0d issued=%0d required 0/0/7", busy, outstanding, cnt);
    end
    step();
    settle();
    n_cmp++;
    if (outstanding !== 4'd0) begin n_bad++; $display("FAIL lim_saturate got=%0d required=0", outstanding); end
    step();
    rd_done = 1'b0;
  endtask

  task automatic test_same_cycle_and_zero();
    set_req(0, 1024, 0);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0001) begin n_bad++; $display("FAIL same_grant got=%b required=0001", pu_req_ready); end
    step();
    pu_req_valid = '0;
    repeat (3) step();
    rd_done = 1'b1;
    settle();
    n_cmp++;
    if ({rd_req, rd_req_size, outstanding} !== {1'b1, 20'd256, 4'd3}) begin
      n_bad++; $display("FAIL same_issue rd_req=%b size=%0d out=%0d required 1/256/3", rd_req, rd_req_size, outstanding);
    end
    step();
    rd_done = 1'b0;
    settle();
    n_cmp++;
    if ({rd_req, outstanding, busy} !== {1'b0, 4'd3, 1'b1}) begin
      n_bad++; $display("FAIL same_hold rd_req=%b out=%0d busy=%b required 0/3/1", rd_req, outstanding, busy);
    end
    step();
    drain(3);
    set_req(2, 0, 2);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0100) begin n_bad++; $display("FAIL zero_grant got=%b required=0100", pu_req_ready); end
    step();
    pu_req_valid = '0;
    settle();
    n_cmp++;
    if ({rd_req, busy, pu_req_ready} !== 6'd0) begin
      n_bad++; $display("FAIL zero_noissue rd_req=%b busy=%b ready=%b required 0/0/0000", rd_req, busy, pu_req_ready);
    end
    step();
    set_req(1, 10, 1);
    set_req(3, 10, 3);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b1000) begin n_bad++; $display("FAIL zero_lastgrant got=%b required=1000", pu_req_ready); end
    step();
    pu_req_valid = '0;
    settle();
    n_cmp++;
    if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type} !== {1'b1, 20'd10, 3'd3, 2'd3}) begin
      n_bad++; $display("FAIL zero_next rd_req=%b size=%0d id=%0d type=%0d required 1/10/3/3",
                        rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type);
    end
    step();
    drain(1);
  endtask

  task automatic test_reset_mid_split();
    set_req(3, 2000, 2);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b1000) begin n_bad++; $display("FAIL rst_grant got=%b required=1000", pu_req_ready); end
    step();
    pu_req_valid = '0;
    step();
    step();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, busy, outstanding, pu_req_ready} !== '0) begin
      n_bad++; $display("FAIL rst_mid rd_req=%b size=%0d id=%0d type=%0d busy=%b out=%0d required all 0",
                        rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type, busy, outstanding);
    end
    step();
    reset_n = 1'b1;
    set_req(3, 5, 2);
    set_req(0, 5, 1);
    settle();
    n_cmp++;
    if (pu_req_ready !== 4'b0001) begin n_bad++; $display("FAIL rst_priority got=%b required=0001", pu_req_ready); end
    step();
    pu_req_valid = '0;
    settle();
    n_cmp++;
    if ({rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type} !== {1'b1, 20'd5, 3'd0, 2'd1}) begin
      n_bad++; $display("FAIL rst_after rd_req=%b size=%0d id=%0d type=%0d required 1/5/0/1",
                        rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type);
    end
    step();
    drain(1);
  endtask

  // Reference model: a request becomes a list of chunk sizes; the in-flight
  // count is a plain integer; grants follow the round-robin search order.
  task automatic test_random();
    int  m_last, m_out, m_id, m_type, h_size, h_id, h_type, g, idx, e_size, e_id, e_type;
    int  chunks[$];
    bit  m_split, exp_rd, done_eff, exp_busy;
    bit  pend[NUM_PU];
    int  psize[NUM_PU];
    int  ptype[NUM_PU];
    logic [NUM_PU-1:0] exp_ready;
    apply_reset();
    m_last = NUM_PU - 1; m_out = 0; m_id = 0; m_type = 0; m_split = 1'b0;
    h_size = 0; h_id = 0; h_type = 0;
    for (int i = 0; i < NUM_PU; i++) begin pend[i] = 1'b0; psize[i] = 0; ptype[i] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_PU; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1;
          ptype[i] = int'($urandom_range(3));
          case ($urandom_range(4))
            0:       psize[i] = 0;
            1:       psize[i] = int'($urandom_range(1, 256));
            2:       psize[i] = MAX_CHUNK * int'($urandom_range(1, 4));
            3:       psize[i] = 257;
            default: psize[i] = int'($urandom_range(1, 1500));
          endcase
        end
        pu_req_valid[i] = pend[i];
        pu_req_size[i*RD_SIZE_W +: RD_SIZE_W] = RD_SIZE_W'(psize[i]);
        pu_req_d_type[i*D_TYPE_W +: D_TYPE_W] = D_TYPE_W'(ptype[i]);
      end
      read_info_full = ($urandom_range(3) == 0);
      rd_done        = ($urandom_range(2) == 0);
      settle();
      g = -1;
      if (!m_split) begin
        for (int k = 1; k <= NUM_PU; k++) begin
          idx = (m_last + k) % NUM_PU;
          if (g < 0 && pend[idx]) g = idx;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_rd = m_split && !read_info_full && (m_out < MAX_OUT);
      if (exp_rd) begin e_size = chunks[0]; e_id = m_id; e_type = m_type; end
      else        begin e_size = h_size;    e_id = h_id; e_type = h_type; end
      exp_busy = m_split || (m_out != 0);
      n_cmp++;
      if (pu_req_ready !== exp_ready) begin
        n_bad++; $display("FAIL rand_ready cyc=%0d got=%b required=%b", cyc, pu_req_ready, exp_ready);
      end
      n_cmp++;
      if (rd_req !== exp_rd) begin
        n_bad++; $display("FAIL rand_rd_req cyc=%0d got=%b required=%b", cyc, rd_req, exp_rd);
      end
      n_cmp++;
      if ({rd_req_size, rd_req_pu_id, rd_req_d_type} !== {RD_SIZE_W'(e_size), 3'(e_id), D_TYPE_W'(e_type)}) begin
        n_bad++; $display("FAIL rand_fields cyc=%0d got=%0d/%0d/%0d required=%0d/%0d/%0d",
                          cyc, rd_req_size, rd_req_pu_id, rd_req_d_type, e_size, e_id, e_type);
      end
      n_cmp++;
      if (outstanding !== 4'(m_out) || busy !== exp_busy) begin
        n_bad++; $display("FAIL rand_out cyc=%0d got=%0d/%b required=%0d/%b", cyc, outstanding, busy, m_out, exp_busy);
      end
      done_eff = rd_done && (m_out > 0);
      if (exp_rd) begin
        h_size = e_size; h_id = e_id; h_type = e_type;
        void'(chunks.pop_front());
        if (chunks.size() == 0) begin m_split = 1'b0; m_last = m_id; end
      end
      if (exp_rd && !done_eff)      m_out++;
      else if (!exp_rd && done_eff) m_out--;
      if (g >= 0) begin
        pend[g] = 1'b0;
        if (psize[g] == 0) begin
          m_last = g;
        end else begin
          m_split = 1'b1; m_id = g; m_type = ptype[g];
          for (int s = psize[g]; s > 0; s -= MAX_CHUNK) chunks.push_back((s > MAX_CHUNK) ? MAX_CHUNK : s);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_split_600();
    test_round_robin();
    test_full_stall();
    test_outstanding_limit();
    test_same_cycle_and_zero();
    test_reset_mid_split();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
